poly_small_keygen_ctrl: RTL and testbench

//   Sequences one small-Gaussian sampler instance to produce the Falcon key polynomials f then g.
//   Per phase, enables the sampler and streams its n signed coefficients to key memory as (sel, addr, data) writes.

---
 rtl/poly_small_keygen_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_poly_small_keygen_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_small_keygen_ctrl.sv
// poly_small_keygen_ctrl
//   Drives one small-Gaussian sampler to produce the key polynomials f and then g. Each phase
//   streams n signed coefficients into key memory as (sel, addr, data) writes. The block
//   accumulates the coefficient parity of each polynomial and the joint squared norm of (f,g).
//   It rejects and restarts a pass as required, and pulses done once an accepted pair is stored.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        one-cycle request for a new (f,g) pair (ignored while busy)
//   abort        cancel the current run; overrides every transition
//   smp_ena      sampler enable (registered)
//   smp_f_valid  sampler coefficient strobe
//   smp_f        sampler coefficient, signed 8-bit
//   coef_we      key-memory write strobe
//   coef_sel     0 = f, 1 = g
//   coef_addr    coefficient index 0..n-1
//   coef_data    signed coefficient (registered copy of smp_f)
//   busy         high whenever not idle
//   done         one-cycle pulse when an accepted pair has been written
//   sq_norm      squared norm of the accepted pair, held from done until the next start
//   retries      rejections in the current run, saturating at 255
module poly_small_keygen_ctrl #(
  parameter int unsigned logn       = 9,
  parameter int unsigned NORM_BOUND = 16823
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic            smp_ena,
  input  logic            smp_f_valid,
  input  logic [7:0]      smp_f,
  output logic            coef_we,
  output logic            coef_sel,
  output logic [logn-1:0] coef_addr,
  output logic [7:0]      coef_data,
  output logic            busy,
  output logic            done,
  output logic [25:0]     sq_norm,
  output logic [7:0]      retries
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSampF = 3'd1;
  localparam logic [2:0] StChkF  = 3'd2;
  localparam logic [2:0] StSampG = 3'd3;
  localparam logic [2:0] StChkG  = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  localparam logic [logn-1:0] LastIdx = '1;
  localparam logic [25:0]     Bound   = 26'(NORM_BOUND);

  logic [2:0]      state_q, state_d;
  logic [logn-1:0] idx_q, idx_d;
  logic [25:0]     norm_q, norm_d;
  logic            parity_q, parity_d;
  logic [7:0]      retries_q, retries_d;
  logic            smp_ena_q, smp_ena_d;
  logic            coef_we_q, coef_we_d;
  logic            coef_sel_q, coef_sel_d;
  logic [logn-1:0] coef_addr_q, coef_addr_d;
  logic [7:0]      coef_data_q, coef_data_d;
  logic            done_q, done_d;
  logic [25:0]     sq_norm_q, sq_norm_d;

  // Square of a signed 8-bit value is at most 16384, so the low 16 bits are the exact magnitude.
  logic signed [15:0] f_ext;
  logic [15:0]        coef_sq;
  assign f_ext   = 16'($signed(smp_f));
  assign coef_sq = f_ext * f_ext;

  logic reject;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    norm_d      = norm_q;
    parity_d    = parity_q;
    retries_d   = retries_q;
    coef_we_d   = 1'b0;
    coef_sel_d  = coef_sel_q;
    coef_addr_d = coef_addr_q;
    coef_data_d = coef_data_q;
    done_d      = 1'b0;
    sq_norm_d   = sq_norm_q;
    reject      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d   = StSampF;
          idx_d     = '0;
          norm_d    = '0;
          parity_d  = 1'b0;
          retries_d = '0;
          sq_norm_d = '0;
        end
      end
      StSampF, StSampG: begin
        if (smp_f_valid) begin
          coef_we_d   = 1'b1;
          coef_sel_d  = (state_q == StSampG);
          coef_addr_d = idx_q;
          coef_data_d = smp_f;
          norm_d      = norm_q + {10'd0, coef_sq};
          parity_d    = parity_q ^ smp_f[0];
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = (state_q == StSampF) ? StChkF : StChkG;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StChkF: begin
        if (!parity_q) begin
          reject = 1'b1;
        end else begin
          // g parity is tracked separately; the norm keeps accumulating across both.
          state_d  = StSampG;
          parity_d = 1'b0;
        end
      end
      StChkG: begin
        if (!parity_q || (norm_q >= Bound)) begin
          reject = 1'b1;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_d    = 1'b1;
        sq_norm_d = norm_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Any rejection redoes the pair from the first f coefficient.
    if (reject) begin
      state_d   = StSampF;
      norm_d    = '0;
      parity_d  = 1'b0;
      retries_d = (retries_q == 8'hFF) ? retries_q : retries_q + 8'd1;
    end

    if (abort) begin
      state_d   = StIdle;
      idx_d     = '0;
      coef_we_d = 1'b0;
      done_d    = 1'b0;
      sq_norm_d = sq_norm_q;
      retries_d = retries_q;
    end

    smp_ena_d = (state_d == StSampF) || (state_d == StSampG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      norm_q      <= '0;
      parity_q    <= 1'b0;
      retries_q   <= '0;
      smp_ena_q   <= 1'b0;
      coef_we_q   <= 1'b0;
      coef_sel_q  <= 1'b0;
      coef_addr_q <= '0;
      coef_data_q <= '0;
      done_q      <= 1'b0;
      sq_norm_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      norm_q      <= norm_d;
      parity_q    <= parity_d;
      retries_q   <= retries_d;
      smp_ena_q   <= smp_ena_d;
      coef_we_q   <= coef_we_d;
      coef_sel_q  <= coef_sel_d;
      coef_addr_q <= coef_addr_d;
      coef_data_q <= coef_data_d;
      done_q      <= done_d;
      sq_norm_q   <= sq_norm_d;
    end
  end

  assign smp_ena   = smp_ena_q;
  assign coef_we   = coef_we_q;
  assign coef_sel  = coef_sel_q;
  assign coef_addr = coef_addr_q;
  assign coef_data = coef_data_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign sq_norm   = sq_norm_q;
  assign retries   = retries_q;

endmodule

// File: tb/tb_poly_small_keygen_ctrl.sv
// Directed bench for poly_small_keygen_ctrl (logn = 9). Every coefficient the bench drives into
// an active sampling phase pushes its expected (sel, addr, data) write onto a queue. A negedge
// monitor pops one entry per coef_we and compares it.
module tb_poly_small_keygen_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic        smp_ena, smp_f_valid;
  logic [7:0]  smp_f;
  logic        coef_we, coef_sel, busy, done;
  logic [8:0]  coef_addr;
  logic [7:0]  coef_data, retries;
  logic [25:0] sq_norm;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0]  poly [512];
  logic [17:0] exp_q [$];

  always #5 clk = ~clk;

  poly_small_keygen_ctrl #(.logn(9), .NORM_BOUND(16823)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .smp_ena     (smp_ena),
    .smp_f_valid (smp_f_valid),
    .smp_f       (smp_f),
    .coef_we     (coef_we),
    .coef_sel    (coef_sel),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .busy        (busy),
    .done        (done),
    .sq_norm     (sq_norm),
    .retries     (retries)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Write monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (coef_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", 32'(coef_we), 32'd0);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check("write", 32'({coef_sel, coef_addr, coef_data}), 32'(e));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sparse polynomial: values at 0, 137, 300, 511; zero elsewhere.
  task automatic load(input int v0, input int v1, input int v2, input int v3);
    for (int i = 0; i < 512; i++) poly[i] = 8'd0;
    poly[0]   = 8'(v0);
    poly[137] = 8'(v1);
    poly[300] = 8'(v2);
    poly[511] = 8'(v3);
  endtask

  // Sampler model: emits poly[first..last_excl-1], one per cycle while smp_ena is high.
  // Leaves smp_f_valid high after the final coefficient; the caller decides the next cycle.
  task automatic stream(input logic sel, input int first, input int last_excl);
    int i;
    int guard;
    i = first;
    guard = 0;
    while (i < last_excl) begin
      tick();
      if (smp_ena === 1'b1) begin
        smp_f_valid = 1'b1;
        smp_f       = poly[i];
        exp_q.push_back({sel, 9'(i), poly[i]});
        i++;
        guard = 0;
      end else begin
        smp_f_valid = 1'b0;
        guard++;
        if (guard > 20) begin
          check("ena_timeout", 32'(smp_ena), 32'd1);
          return;
        end
      end
    end
  endtask

  task automatic do_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called right after the last g coefficient has been driven.
  task automatic expect_done(input int exp_norm, input int exp_retries);
    tick();
    smp_f_valid = 1'b0;
    check("chk_g_ena", 32'(smp_ena), 32'd0);
    check("chk_g_done", 32'(done), 32'd0);
    tick();
    check("done_early", 32'(done), 32'd0);
    tick();
    check("done_pulse", 32'(done), 32'd1);
    check("sq_norm", 32'(sq_norm), 32'(exp_norm));
    check("retries", 32'(retries), 32'(exp_retries));
    check("busy_after_done", 32'(busy), 32'd0);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("sq_norm_hold", 32'(sq_norm), 32'(exp_norm));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, 32'(coef_we), 32'd0);
    check({tag, "_sel"}, 32'(coef_sel), 32'd0);
    check({tag, "_addr"}, 32'(coef_addr), 32'd0);
    check({tag, "_data"}, 32'(coef_data), 32'd0);
    check({tag, "_ena"}, 32'(smp_ena), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_norm"}, 32'(sq_norm), 32'd0);
    check({tag, "_retries"}, 32'(retries), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; smp_f_valid = 1'b0; smp_f = 8'd0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Idle valid pulses must not write; start together with abort stays idle.
    smp_f_valid = 1'b1; smp_f = 8'd7;
    tick(); tick(); tick();
    check("idle_busy", 32'(busy), 32'd0);
    smp_f_valid = 1'b0;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_ena", 32'(smp_ena), 32'd0);

    // 1: clean pair, norm 3609 + 391 = 4000.
    do_start();
    check("run_busy", 32'(busy), 32'd1);
    load(-60, 3, 0, 0);
    stream(1'b0, 0, 512);
    tick();
    smp_f_valid = 1'b0;
    check("chk_f_ena", 32'(smp_ena), 32'd0);
    load(19, 5, 2, 1);
    stream(1'b1, 0, 512);
    expect_done(4000, 0);

    // 2: first f pass has even parity -> CHK_F reject. The stray valid in CHK_F is ignored.
    do_start();
    load(2, 3, -1, 0);
    stream(1'b0, 0, 512);
    tick();
    check("rej_f_ena_low", 32'(smp_ena), 32'd0);
    tick();
    smp_f_valid = 1'b0;
    check("rej_f_ena_high", 32'(smp_ena), 32'd1);
    check("rej_f_retries", 32'(retries), 32'd1);
    load(-60, 3, 0, 0);
    stream(1'b0, 0, 512);
    tick();
    smp_f_valid = 1'b0;
    load(19, 5, 2, 1);
    stream(1'b1, 0, 512);
    expect_done(4000, 1);

    // 3: norm 16145 + 679 = 16824 rejected at CHK_G; then 16145 + 677 = 16822 accepted.
    do_start();
    load(127, 4, 0, 0);
    stream(1'b0, 0, 512);
    tick();
    smp_f_valid = 1'b0;
    load(25, -7, 2, 1);
    stream(1'b1, 0, 512);
    tick();
    smp_f_valid = 1'b0;
    check("rej_g_ena_low", 32'(smp_ena), 32'd0);
    tick();
    check("rej_g_ena_high", 32'(smp_ena), 32'd1);
    check("rej_g_retries", 32'(retries), 32'd1);
    check("rej_g_done", 32'(done), 32'd0);
    load(127, 4, 0, 0);
    stream(1'b0, 0, 512);
    tick();
    smp_f_valid = 1'b0;
    load(-26, 1, 0, 0);
    stream(1'b1, 0, 512);
    expect_done(16822, 1);

    // 4: abort on g coefficient 300; later valids are dropped and no done appears.
    do_start();
    load(-60, 3, 0, 0);
    stream(1'b0, 0, 512);
    tick();
    smp_f_valid = 1'b0;
    load(19, 5, 2, 1);
    stream(1'b1, 0, 300);
    tick();
    smp_f_valid = 1'b1; smp_f = poly[300]; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ena", 32'(smp_ena), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("abort_no_done", 32'(done), 32'd0);
    end
    smp_f_valid = 1'b0;
    check("abort_retries", 32'(retries), 32'd0);

    // 6a: synchronous reset mid SAMP_F, with a valid in the reset cycle.
    do_start();
    load(-60, 3, 0, 0);
    stream(1'b0, 0, 100);
    tick();
    rst = 1'b1; smp_f = poly[100];
    tick();
    rst = 1'b0; smp_f_valid = 1'b0;
    check_all_zero("midrst");

    // 6b: start while busy leaves retries and the address sequence untouched.
    do_start();
    load(2, 3, -1, 0);
    stream(1'b0, 0, 512);
    tick();
    smp_f_valid = 1'b0;
    load(-60, 3, 0, 0);
    stream(1'b0, 0, 200);
    start = 1'b1;
    stream(1'b0, 200, 201);
    start = 1'b0;
    stream(1'b0, 201, 512);
    tick();
    smp_f_valid = 1'b0;
    load(19, 5, 2, 1);
    stream(1'b1, 0, 512);
    expect_done(4000, 1);

    tick();
    tick();
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
